uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised UART receiver for the APB/UART/GPIO subsystem. It generalises the fixed 32-bit receiver with configurable data width, parity mode and stop-bit count. It adds error detection (parity, framing, overrun) and a valid/ready output handshake. It sits between the serial pin and the APB UART register block, which drains received words through the handshake.

Parameters:
CLKS_PER_BIT, 10416, clk cycles per serial bit; must be >= 4
DATA_BITS, 32, data bits per frame, 1..32, LSB first
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, number of stop bits, 1 or 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
enable  input  1  receiver enable; low aborts any frame in progress
serial_in  input  1  asynchronous serial line, idle high
rx_data  output  DATA_BITS  received word, stable while rx_valid = 1
rx_valid  output  1  word available; held until accepted
rx_ready  input  1  consumer accepts the word when rx_valid & rx_ready
parity_err  output  1  parity mismatch for the word in rx_data; 0 when PARITY_MODE = 0
frame_err  output  1  a stop bit was sampled low for the word in rx_data
overrun  output  1  sticky; a frame completed while rx_valid was already 1
busy  output  1  FSM not in IDLE

Behaviour:
- Interface: reset rst, asynchronous, active-low; clock clk.
- Reset values: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0, busy = 0. FSM = IDLE, counters = 0, synchroniser flops = 1.
- serial_in passes through a 2-flop synchroniser (sin_s). All decisions use sin_s.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: clear bit counter and clock counter. If enable and sin_s = 0, go to START.
- START: count to CLKS_PER_BIT/2 - 1 (integer division), then resample.
  - If sin_s = 0: clear the counter, go to DATA.
  - If sin_s = 1: treat as a glitch, go to IDLE. No flags change.
- DATA: sample point is counter = CLKS_PER_BIT-1.
  - At the sample point, store the bit at index bit_idx in the shift register and clear the counter.
  - After bit DATA_BITS-1, go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY: sample at CLKS_PER_BIT-1.
  - Even mode: error if XOR(data, parity bit) = 1.
  - Odd mode: error if XOR(data, parity bit) = 0.
- STOP: sample STOP_BITS bits at CLKS_PER_BIT-1 each. Any low sample sets the frame error.
  - At the last stop-bit sample point, the frame completes and the FSM returns to IDLE in the same cycle. Back-to-back frames are therefore accepted.
- Completion, on the clock edge after the final stop sample:
  - If rx_valid = 0: load rx_data, parity_err and frame_err; set rx_valid = 1.
  - If rx_valid = 1 and not accepted this cycle: drop the new frame, keep the old data, set overrun = 1.
  - If rx_valid = 1 and it is being accepted this same cycle: load the new frame; no overrun.
- Handshake: on rx_valid & rx_ready, clear rx_valid on the next edge. Clear overrun on the same edge.
- A frame with frame_err is still delivered, with frame_err = 1.
- enable low: the FSM goes to IDLE on the next edge and the partial frame is discarded. rx_valid, rx_data and the error flags are unaffected.
- rst asserted mid-frame: immediate return to reset values. A line still low after release is treated as a new start, and the start check rejects it if it is not a genuine start bit.

Optional Feature:
RX_MAJORITY_VOTE_EN
- Defined: each data, parity and stop bit is the 2-of-3 majority of sin_s sampled at counter = CLKS_PER_BIT-3, -2 and -1. The decision is made at -1. The start check stays a single sample.
- Undefined: a single sample at CLKS_PER_BIT-1. Same timing and latency either way.

Test Plan:
- CLKS_PER_BIT=16, DATA_BITS=8, PARITY_MODE=0: send 0xA5, rx_ready=0 -> rx_valid=1 with rx_data=0xA5 and no errors. Assert rx_ready for one cycle -> rx_valid=0 on the next edge.
- PARITY_MODE=1: send 0x03 with parity bit 0 -> parity_err=0. Send 0x03 with parity bit 1 -> parity_err=1 and rx_data=0x03.
- Stop bit driven low: send 0x5A -> rx_valid=1, frame_err=1, rx_data=0x5A.
- Overrun: send 0x11, then 0x22 back-to-back without rx_ready -> rx_data stays 0x11 and overrun=1. Accept -> overrun=0.
- Glitch and abort:
  - A 3-cycle low pulse on serial_in -> busy returns to 0 and rx_valid stays 0.
  - Drop enable mid-DATA, then send 0x7E -> only 0x7E is delivered.
- RX_MAJORITY_VOTE_EN defined: a 1-cycle inverted glitch at the centre of every bit of 0xC3 -> rx_data=0xC3. With the macro undefined, the same stimulus produces corrupted data.

Source files
------------

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//
// Parametrised UART receiver. Samples an asynchronous serial line and
// assembles frames of DATA_BITS data bits (LSB first), an optional parity
// bit and one or two stop bits. Received words are handed to the consumer
// through a valid/ready handshake. Parity, framing and overrun errors are
// reported alongside the word.
//
// Parameters:
//    CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//    DATA_BITS     data bits per frame, 1..32
//    PARITY_MODE   0 = none, 1 = even, 2 = odd
//    STOP_BITS     number of stop bits, 1 or 2
//
// Ports:
//    clk         system clock
//    rst         asynchronous reset, active-low
//    enable      receiver enable; low aborts any frame in progress
//    serial_in   asynchronous serial line, idle high
//    rx_data     received word, stable while rx_valid = 1
//    rx_valid    word available; held until accepted
//    rx_ready    consumer accepts the word when rx_valid & rx_ready
//    parity_err  parity mismatch for the word in rx_data
//    frame_err   a stop bit was sampled low for the word in rx_data
//    overrun     sticky; a frame completed while rx_valid was already 1
//    busy        receiver FSM is not idle
//
// Optional feature macro: RX_MAJORITY_VOTE_EN
//    When defined, every data, parity and stop bit is the 2-of-3 majority
//    of the synchronised line sampled at counter = CLKS_PER_BIT-3, -2 and
//    -1, with the decision taken at -1. When undefined, a single sample is
//    taken at CLKS_PER_BIT-1. Timing and latency are identical either way.
//    The start-bit check is always a single sample.
// ---------------------------------------------------------------------------
module uart_rx_param #(
   parameter int CLKS_PER_BIT = 10416,
   parameter int DATA_BITS    = 32,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   // Widths of the bit-period counter and of the data bit index.
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   // Counter values where decisions are taken. The start bit is checked at
   // its middle so that every later sample lands near the middle of its bit.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t               state_q, state_d;
   logic                 sync1_q;
   logic                 sin_s_q;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic                 stop_idx_q, stop_idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_err_q, par_err_d;
   logic                 fr_err_q, fr_err_d;

   logic [DATA_BITS-1:0] rx_data_q;
   logic                 rx_valid_q;
   logic                 parity_err_q;
   logic                 frame_err_q;
   logic                 overrun_q;

   logic                 sample_bit;
   logic                 frame_done;
   logic                 done_fr_err;
   logic                 accept;

   // Two-flop synchroniser for the asynchronous serial line. Both flops
   // reset to the idle-high level so that reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 1'b1;
         sin_s_q <= 1'b1;
      end else begin
         sync1_q <= serial_in;
         sin_s_q <= sync1_q;
      end
   end

`ifdef RX_MAJORITY_VOTE_EN
   localparam logic [CNT_W-1:0] CNT_M3 = CNT_W'(CLKS_PER_BIT - 3);
   localparam logic [CNT_W-1:0] CNT_M2 = CNT_W'(CLKS_PER_BIT - 2);

   logic [1:0] vote_q, vote_d;

   // Capture the two early votes of each bit. They are taken in every state;
   // only the bit-sampling states ever combine them into a decision.
   always_comb begin
      vote_d = vote_q;
      if (cnt_q == CNT_M3) begin
         vote_d[0] = sin_s_q;
      end
      if (cnt_q == CNT_M2) begin
         vote_d[1] = sin_s_q;
      end
   end

   // Hold the early votes until the decision point at CLKS_PER_BIT-1.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vote_q <= 2'b11;
      end else begin
         vote_q <= vote_d;
      end
   end

   // 2-of-3 majority of the early votes and the current sample, so a single
   // cycle of line noise near the bit centre cannot flip the decision.
   always_comb begin
      sample_bit = (vote_q[0] & vote_q[1]) |
                   (vote_q[0] & sin_s_q)   |
                   (vote_q[1] & sin_s_q);
   end
`else
   // Without voting the bit value is simply the line at the decision point.
   always_comb begin
      sample_bit = sin_s_q;
   end
`endif

   // Receiver state and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         shift_q    <= '0;
         par_err_q  <= 1'b0;
         fr_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         stop_idx_q <= stop_idx_d;
         shift_q    <= shift_d;
         par_err_q  <= par_err_d;
         fr_err_q   <= fr_err_d;
      end
   end

   // Next-state logic. The counter free-runs inside a bit and is cleared at
   // each decision point. frame_done pulses on the final stop-bit sample,
   // which is also where the FSM drops back to idle, so a new start bit can
   // follow the stop bit immediately. Dropping enable overrides everything
   // and discards the partial frame.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      bit_idx_d   = bit_idx_q;
      stop_idx_d  = stop_idx_q;
      shift_d     = shift_q;
      par_err_d   = par_err_q;
      fr_err_d    = fr_err_q;
      frame_done  = 1'b0;
      done_fr_err = fr_err_q;

      case (state_q)
         S_IDLE: begin
            cnt_d      = '0;
            bit_idx_d  = '0;
            stop_idx_d = 1'b0;
            par_err_d  = 1'b0;
            fr_err_d   = 1'b0;
            if (enable && !sin_s_q) begin
               state_d = S_START;
            end
         end

         S_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (sin_s_q) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
               end
            end
         end

         S_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               shift_d[bit_idx_q] = sample_bit;
               if (bit_idx_q == IDX_LAST) begin
                  bit_idx_d = '0;
                  if (PARITY_MODE != 0) begin
                     state_d = S_PARITY;
                  end else begin
                     state_d = S_STOP;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end
         end

         S_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (PARITY_MODE == 2) begin
                  par_err_d = ~(^shift_q ^ sample_bit);
               end else begin
                  par_err_d = ^shift_q ^ sample_bit;
               end
               state_d = S_STOP;
            end
         end

         S_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (!sample_bit) begin
                  fr_err_d = 1'b1;
               end
               if (stop_idx_q == STOP_LAST) begin
                  frame_done  = 1'b1;
                  done_fr_err = fr_err_q | ~sample_bit;
                  state_d     = S_IDLE;
               end else begin
                  stop_idx_d = stop_idx_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (!enable) begin
         state_d    = S_IDLE;
         frame_done = 1'b0;
      end
   end

   assign accept = rx_valid_q & rx_ready;

   // Output word and handshake. A completed frame is loaded when the holding
   // register is empty or is being drained on this very edge; otherwise the
   // new frame is dropped and overrun is raised. Acceptance clears both
   // rx_valid and the sticky overrun flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data_q    <= '0;
         rx_valid_q   <= 1'b0;
         parity_err_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         if (frame_done) begin
            if (!rx_valid_q || accept) begin
               rx_data_q    <= shift_q;
               parity_err_q <= par_err_q;
               frame_err_q  <= done_fr_err;
               rx_valid_q   <= 1'b1;
               overrun_q    <= 1'b0;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (accept) begin
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
         end
      end
   end

   assign rx_data    = rx_data_q;
   assign rx_valid   = rx_valid_q;
   assign parity_err = parity_err_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign busy       = (state_q != S_IDLE);

endmodule
